// File: rtl/fifo_data_stage.sv
`default_nettype none
// ============================================================================
// fifo_data_stage : FIFO storage array with a 2-deep registered output buffer
// Revision 1.0    : initial release
// ============================================================================
module fifo_data_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              wr,
  output logic              rd,
  input  logic              emp,
  input  logic              full,
  input  logic [ADDR_W:0]   wr_ptr,
  input  logic [ADDR_W:0]   rd_ptr,
  output logic [ADDR_W+1:0] level,
  output logic              ovf_err
);

  localparam int c_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OB_EMPTY = 2'd0,
    OB_ONE   = 2'd1,
    OB_TWO   = 2'd2
  } ob_state_t;

  ob_state_t          r_state;
  ob_state_t          w_state_nxt;
  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [DATA_W-1:0]  r_head;
  logic [DATA_W-1:0]  r_skid;
  logic [DATA_W-1:0]  w_head_nxt;
  logic [DATA_W-1:0]  w_skid_nxt;
  logic [DATA_W-1:0]  w_rd_word;
  logic               r_ovf;
  logic               w_out_valid;
  logic               w_pop;
  logic               w_fetch;
  logic [1:0]         w_ocnt;
  logic [ADDR_W:0]    w_ptr_diff;

  assign in_ready    = !full;
  assign wr          = in_valid;
  assign w_out_valid = (r_state != OB_EMPTY);
  assign out_valid   = w_out_valid;
  assign out_data    = r_head;
  assign ovf_err     = r_ovf;

  assign w_pop     = w_out_valid && out_ready;
  // A full buffer may only fetch when the head leaves in the same cycle.
  assign rd        = !emp && ((r_state != OB_TWO) || w_pop);
  assign w_fetch   = rd;
  assign w_rd_word = r_mem[rd_ptr[ADDR_W-1:0]];

  assign w_ocnt     = r_state;
  assign w_ptr_diff = wr_ptr - rd_ptr;
  assign level      = {1'b0, w_ptr_diff} + {{ADDR_W{1'b0}}, w_ocnt};

  // Storage array: no reset, written only while the controller has room.
  always_ff @(posedge clk) begin
    if (in_valid && !full) begin
      r_mem[wr_ptr[ADDR_W-1:0]] <= in_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    case (r_state)
      OB_EMPTY: begin
        if (w_fetch) begin
          w_state_nxt = OB_ONE;
          w_head_nxt  = w_rd_word;
        end
      end
      OB_ONE: begin
        if (w_fetch && w_pop) begin
          w_head_nxt = w_rd_word;
        end else if (w_fetch) begin
          w_state_nxt = OB_TWO;
          w_skid_nxt  = w_rd_word;
        end else if (w_pop) begin
          w_state_nxt = OB_EMPTY;
        end
      end
      OB_TWO: begin
        if (w_pop) begin
          w_head_nxt = r_skid;
          if (w_fetch) begin
            w_skid_nxt = w_rd_word;
          end else begin
            w_state_nxt = OB_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = OB_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OB_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_skid  <= w_skid_nxt;
      if (in_valid && full) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
